regfile_wr_decoder: RTL

Registered, parametrised N-to-2^N write-enable decoder for the register file write port, placed between the write-back stage and the register array. It turns a write address and enable into a one-hot row enable, one cycle after the request. It always suppresses the hard-wired zero register. It also contains a clear sequencer that sweeps every row once, after reset or on request, so that the register file starts from a known all-zero state.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_wr_decoder_if.sv | 17 +
 rtl/decoder_n.sv | 17 +
 rtl/regfile_wr_decoder.sv | 85 ++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the register-file write-enable decoder.
package regfile_pkg;

   localparam int ADDR_W_DEF = 5;
   localparam int NROWS_DEF  = 1 << ADDR_W_DEF;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } wrdec_state_t;

   // One-hot row vector for the default address width.
   function automatic logic [NROWS_DEF-1:0] onehot(input logic [ADDR_W_DEF-1:0] addr);
      logic [NROWS_DEF-1:0] v;
      v       = '0;
      v[addr] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/regfile_wr_decoder_if.sv
// Write-back to register-file write-port bus: request side plus row enables.
interface regfile_wr_decoder_if
   import regfile_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
);
   logic                     en;
   logic [ADDR_W-1:0]        addr;
   logic                     clr_req;
   logic [(1<<ADDR_W)-1:0]   out;
   logic                     clr_wr;
   logic                     busy;
   logic                     drop;

   modport master (output en, addr, clr_req, input out, clr_wr, busy, drop);
   modport slave  (input en, addr, clr_req, output out, clr_wr, busy, drop);
endinterface

// File: rtl/decoder_n.sv
// Combinational ADDR_W-to-2^ADDR_W decoder with enable.
module decoder_n
   import regfile_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic [ADDR_W-1:0]      sel,
   input  logic                   en,
   output logic [(1<<ADDR_W)-1:0] dec
);
   localparam int NROWS = 1 << ADDR_W;

   // One comparator per row; at most one matches.
   for (genvar i = 0; i < NROWS; i++) begin : g_row
      assign dec[i] = en && (sel == ADDR_W'(i));
   end
endmodule

// File: rtl/regfile_wr_decoder.sv
// Registered write-enable decoder with zero-register masking and a
// clear sequencer that sweeps every row once (after reset or on request).
module regfile_wr_decoder
   import regfile_pkg::*;
#(
   parameter int ADDR_W         = ADDR_W_DEF,
   parameter int ZERO_IDX       = (1 << ADDR_W) - 1,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   regfile_wr_decoder_if.slave  bus
);
   localparam int                NROWS = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST  = '1;
   localparam logic [NROWS-1:0]  ZMASK = {{(NROWS-1){1'b0}}, 1'b1} << ZERO_IDX;

   wrdec_state_t       state_q, state_d;
   logic [ADDR_W-1:0]  idx_q, idx_d;
   logic [NROWS-1:0]   out_q, out_d;
   logic               clr_wr_q, clr_wr_d;
   logic               drop_q, drop_d;

   logic [ADDR_W-1:0]  sel;
   logic               dec_en;
   logic [NROWS-1:0]   dec;

   // Single shared decoder: sweep index while sweeping, write address otherwise.
   // A clear request in IDLE wins over a same-cycle write, so that write is not decoded.
   assign sel    = (state_q == SWEEP) ? idx_q : bus.addr;
   assign dec_en = (state_q == SWEEP) || (bus.en && !bus.clr_req);

   decoder_n #(.ADDR_W(ADDR_W)) u_dec (
      .sel (sel),
      .en  (dec_en),
      .dec (dec)
   );

   // Next-state, sweep index and registered-output values.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      clr_wr_d = 1'b0;
      drop_d   = 1'b0;
      out_d    = dec & ~ZMASK;
      case (state_q)
         IDLE: begin
            drop_d = bus.clr_req && bus.en;
            if (bus.clr_req) begin
               state_d = SWEEP;
               idx_d   = '0;
            end
         end
         SWEEP: begin
            clr_wr_d = 1'b1;
            drop_d   = bus.en;
            idx_d    = idx_q + 1'b1;
            if (idx_q == LAST) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset optionally lands straight in a sweep.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= CLEAR_ON_RESET ? SWEEP : IDLE;
         idx_q    <= '0;
         out_q    <= '0;
         clr_wr_q <= 1'b0;
         drop_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         out_q    <= out_d;
         clr_wr_q <= clr_wr_d;
         drop_q   <= drop_d;
      end
   end

   assign bus.out    = out_q;
   assign bus.clr_wr = clr_wr_q;
   assign bus.drop   = drop_q;
   assign bus.busy   = (state_q == SWEEP);
endmodule
